lpc_cycle_decoder: RTL and testbench

// Passive LPC bus decoder: successor to the single-mode IO sniffer core. Snoops lpc_ad/lpc_frame and

---
 rtl/lpc_cycle_decoder_pkg.sv | 49 ++++
 rtl/lpc_cycle_decoder_nibble_shift.sv | 43 ++++
 rtl/lpc_cycle_decoder.sv | 254 +++++++++++++++++++++++++
 tb/tb_lpc_cycle_decoder.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_cycle_decoder_pkg.sv
// Shared definitions for the passive LPC cycle decoder: FSM states, start/SYNC codes and
// cycle-type encodings, plus small decode helpers.
package lpc_cycle_decoder_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StCtDir,
    StFwhIdsel,
    StAddr,
    StFwhMsize,
    StDataW,
    StTar1,
    StSync,
    StDataR,
    StTar2,
    StDrop
  } lpc_state_e;

  localparam logic [3:0] StartLpc   = 4'b0000;
  localparam logic [3:0] StartFwhRd = 4'b1101;
  localparam logic [3:0] StartFwhWr = 4'b1110;
  localparam logic [3:0] StartAbort = 4'b1111;

  localparam logic [3:0] SyncReady     = 4'b0000;
  localparam logic [3:0] SyncShortWait = 4'b0101;
  localparam logic [3:0] SyncLongWait  = 4'b0110;
  localparam logic [3:0] SyncError     = 4'b1010;

  localparam logic [1:0] CycIo  = 2'b00;
  localparam logic [1:0] CycMem = 2'b01;
  localparam logic [1:0] CycFwh = 2'b11;

  // FWH MSIZE to byte count; 0 marks an unsupported size.
  function automatic logic [2:0] msize_bytes(input logic [3:0] msize);
    case (msize)
      4'b0000: return 3'd1;
      4'b0001: return 3'd2;
      4'b0010: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // States in which LFRAME# has already risen and a cycle is in flight.
  function automatic logic in_cycle(input lpc_state_e st);
    return st inside {StAddr, StFwhMsize, StDataW, StTar1, StSync, StDataR, StTar2, StDrop};
  endfunction

endpackage

// File: rtl/lpc_cycle_decoder_nibble_shift.sv
// Nibble assembly for the LPC decoder: address shifts in MSB-first, data nibbles are placed
// LSB-first by index. Exposes next-state values so a record can capture the final nibble.
module lpc_cycle_decoder_nibble_shift (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        addr_shift_i,
  input  logic        data_load_i,
  input  logic [2:0]  data_idx_i,
  input  logic [3:0]  nibble_i,
  output logic [31:0] addr_next_o,
  output logic [31:0] data_next_o
);

  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    if (clear_i) begin
      addr_d = '0;
      data_d = '0;
    end else begin
      if (addr_shift_i) addr_d = {addr_q[27:0], nibble_i};
      if (data_load_i) data_d[{data_idx_i, 2'b00} +: 4] = nibble_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= '0;
      data_q <= '0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign addr_next_o = addr_d;
  assign data_next_o = data_d;

endmodule

// File: rtl/lpc_cycle_decoder.sv
// Passive LPC snooper: decodes IO, memory and FWH cycles from LAD/LFRAME# and emits one
// registered record per completed cycle, plus abort and SYNC-error strobes.
module lpc_cycle_decoder
  import lpc_cycle_decoder_pkg::*;
#(
  parameter int unsigned MAX_DATA_BYTES = 4,
  parameter int unsigned SYNC_TIMEOUT   = 255,
  parameter int unsigned ENABLE_FWH     = 1
) (
  input  logic        lpc_clock,
  input  logic        lpc_reset,
  input  logic [3:0]  lpc_ad,
  input  logic        lpc_frame,
  output logic [3:0]  out_cyctype_dir,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  output logic [2:0]  out_data_size,
  output logic        out_clock_enable,
  output logic        out_abort,
  output logic        out_sync_err
);

  localparam int unsigned WaitW = (SYNC_TIMEOUT < 1) ? 1 : $clog2(SYNC_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(SYNC_TIMEOUT - 1);

  lpc_state_e       state_q, state_d;
  logic [3:0]       nib_cnt_q, nib_cnt_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]       cyc_q, cyc_d;
  logic             write_q, write_d;
  logic [3:0]       addr_last_q, addr_last_d;
  logic [2:0]       bytes_q, bytes_d;
  logic             err_q, err_d;
  logic [3:0]       rec_ctdir_q, rec_ctdir_d;
  logic [31:0]      rec_addr_q, rec_addr_d;
  logic [31:0]      rec_data_q, rec_data_d;
  logic [2:0]       rec_size_q, rec_size_d;
  logic             strobe_q, strobe_d;
  logic             abort_q, abort_d;
  logic             sync_err_q, sync_err_d;

  logic        sh_clear, sh_addr, sh_data;
  logic [31:0] addr_nxt, data_nxt;
  logic [3:0]  data_last;
  logic [2:0]  msz;

  lpc_cycle_decoder_nibble_shift u_shift (
    .clk_i        (lpc_clock),
    .rst_i        (lpc_reset),
    .clear_i      (sh_clear),
    .addr_shift_i (sh_addr),
    .data_load_i  (sh_data),
    .data_idx_i   (nib_cnt_q[2:0]),
    .nibble_i     (lpc_ad),
    .addr_next_o  (addr_nxt),
    .data_next_o  (data_nxt)
  );

  assign data_last = {bytes_q, 1'b0} - 4'd1;
  assign msz       = msize_bytes(lpc_ad);

  always_comb begin
    state_d     = state_q;
    nib_cnt_d   = nib_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    cyc_d       = cyc_q;
    write_d     = write_q;
    addr_last_d = addr_last_q;
    bytes_d     = bytes_q;
    err_d       = err_q;
    rec_ctdir_d = rec_ctdir_q;
    rec_addr_d  = rec_addr_q;
    rec_data_d  = rec_data_q;
    rec_size_d  = rec_size_q;
    strobe_d    = 1'b0;
    abort_d     = 1'b0;
    sync_err_d  = 1'b0;
    sh_clear    = 1'b0;
    sh_addr     = 1'b0;
    sh_data     = 1'b0;

    if (!lpc_frame) begin
      // The state reached while LFRAME# is low remembers the latest start nibble.
      abort_d = in_cycle(state_q) && (lpc_ad == StartAbort);
      write_d = (lpc_ad == StartFwhWr);
      if (lpc_ad == StartLpc) begin
        state_d = StCtDir;
      end else if ((ENABLE_FWH != 0) && ((lpc_ad == StartFwhRd) || (lpc_ad == StartFwhWr))) begin
        state_d = StFwhIdsel;
      end else begin
        state_d = StStart;
      end
    end else begin
      case (state_q)
        StStart: state_d = StIdle;
        StCtDir: begin
          if (lpc_ad[3]) begin
            state_d = StIdle;
          end else begin
            cyc_d       = lpc_ad[2] ? CycMem : CycIo;
            write_d     = lpc_ad[1];
            addr_last_d = lpc_ad[2] ? 4'd7 : 4'd3;
            bytes_d     = 3'd1;
            nib_cnt_d   = '0;
            err_d       = 1'b0;
            sh_clear    = 1'b1;
            state_d     = StAddr;
          end
        end
        StFwhIdsel: begin
          cyc_d       = CycFwh;
          addr_last_d = 4'd6;
          nib_cnt_d   = '0;
          err_d       = 1'b0;
          sh_clear    = 1'b1;
          state_d     = StAddr;
        end
        StAddr: begin
          sh_addr = 1'b1;
          if (nib_cnt_q == addr_last_q) begin
            nib_cnt_d = '0;
            if (cyc_q == CycFwh) state_d = StFwhMsize;
            else                 state_d = write_q ? StDataW : StTar1;
          end else begin
            nib_cnt_d = nib_cnt_q + 4'd1;
          end
        end
        StFwhMsize: begin
          bytes_d = msz;
          if ((msz == 3'd0) || (32'(msz) > MAX_DATA_BYTES)) state_d = StDrop;
          else state_d = write_q ? StDataW : StTar1;
        end
        StDataW: begin
          sh_data = 1'b1;
          if (nib_cnt_q == data_last) begin
            nib_cnt_d = '0;
            state_d   = StTar1;
          end else begin
            nib_cnt_d = nib_cnt_q + 4'd1;
          end
        end
        StTar1: begin
          if (nib_cnt_q == 4'd1) begin
            nib_cnt_d  = '0;
            wait_cnt_d = '0;
            state_d    = StSync;
          end else begin
            nib_cnt_d = nib_cnt_q + 4'd1;
          end
        end
        StSync: begin
          case (lpc_ad)
            SyncReady, SyncError: begin
              err_d     = (lpc_ad == SyncError);
              nib_cnt_d = '0;
              if (write_q) begin
                strobe_d    = 1'b1;
                sync_err_d  = (lpc_ad == SyncError);
                rec_ctdir_d = {cyc_q, write_q, 1'b0};
                rec_addr_d  = addr_nxt;
                rec_data_d  = data_nxt;
                rec_size_d  = bytes_q;
                state_d     = StTar2;
              end else begin
                state_d = StDataR;
              end
            end
            SyncShortWait, SyncLongWait: begin
              if (wait_cnt_q == WaitLast) begin
                sync_err_d = 1'b1;
                state_d    = StIdle;
              end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
              end
            end
            default: begin
              sync_err_d = 1'b1;
              state_d    = StIdle;
            end
          endcase
        end
        StDataR: begin
          sh_data = 1'b1;
          if (nib_cnt_q == data_last) begin
            strobe_d    = 1'b1;
            sync_err_d  = err_q;
            rec_ctdir_d = {cyc_q, write_q, 1'b0};
            rec_addr_d  = addr_nxt;
            rec_data_d  = data_nxt;
            rec_size_d  = bytes_q;
            nib_cnt_d   = '0;
            state_d     = StTar2;
          end else begin
            nib_cnt_d = nib_cnt_q + 4'd1;
          end
        end
        StTar2: begin
          if (nib_cnt_q == 4'd1) begin
            nib_cnt_d = '0;
            state_d   = StIdle;
          end else begin
            nib_cnt_d = nib_cnt_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge lpc_clock) begin
    if (lpc_reset) begin
      state_q     <= StIdle;
      nib_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      cyc_q       <= CycIo;
      write_q     <= 1'b0;
      addr_last_q <= '0;
      bytes_q     <= '0;
      err_q       <= 1'b0;
      rec_ctdir_q <= '0;
      rec_addr_q  <= '0;
      rec_data_q  <= '0;
      rec_size_q  <= '0;
      strobe_q    <= 1'b0;
      abort_q     <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      nib_cnt_q   <= nib_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      cyc_q       <= cyc_d;
      write_q     <= write_d;
      addr_last_q <= addr_last_d;
      bytes_q     <= bytes_d;
      err_q       <= err_d;
      rec_ctdir_q <= rec_ctdir_d;
      rec_addr_q  <= rec_addr_d;
      rec_data_q  <= rec_data_d;
      rec_size_q  <= rec_size_d;
      strobe_q    <= strobe_d;
      abort_q     <= abort_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign out_cyctype_dir  = rec_ctdir_q;
  assign out_addr         = rec_addr_q;
  assign out_data         = rec_data_q;
  assign out_data_size    = rec_size_q;
  assign out_clock_enable = strobe_q;
  assign out_abort        = abort_q;
  assign out_sync_err     = sync_err_q;

endmodule

// File: tb/tb_lpc_cycle_decoder.sv
// Bench for lpc_cycle_decoder: directed LPC/FWH cycles and randomized back-to-back traffic,
// checked against a transaction-level model on a default and a narrow/short-timeout instance.
module tb_lpc_cycle_decoder;

  localparam int KIo = 0;
  localparam int KMem = 1;
  localparam int KFwh = 2;
  localparam int Max2 = 2;
  localparam int Tmo2 = 4;

  typedef struct {
    int          kind;
    bit          write;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  msize;
    int          nbytes;
    int          pre;
    logic [3:0]  pre_nib;
    int          nwait;
    logic [3:0]  wait_code;
    logic [3:0]  sync_final;
  } txn_t;

  typedef struct {
    bit          rec;
    bit          serr;
    logic [3:0]  ct;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  size;
  } exp_t;

  logic       lpc_clock = 1'b0;
  logic       lpc_reset = 1'b1;
  logic       lpc_frame = 1'b1;
  logic [3:0] lpc_ad = 4'hf;

  logic [3:0]  ct [2];
  logic [31:0] ad [2];
  logic [31:0] dt [2];
  logic [2:0]  sz [2];
  logic        ce [2];
  logic        ab [2];
  logic        se [2];

  int n_checks = 0;
  int n_pass = 0;
  int n_ce [2] = '{0, 0};
  int n_se [2] = '{0, 0};
  int n_ab [2] = '{0, 0};
  logic mark_ce [2];
  logic mark_se [2];

  lpc_cycle_decoder dut (
    .lpc_clock(lpc_clock), .lpc_reset(lpc_reset), .lpc_ad(lpc_ad), .lpc_frame(lpc_frame),
    .out_cyctype_dir(ct[0]), .out_addr(ad[0]), .out_data(dt[0]), .out_data_size(sz[0]),
    .out_clock_enable(ce[0]), .out_abort(ab[0]), .out_sync_err(se[0])
  );

  lpc_cycle_decoder #(.MAX_DATA_BYTES(Max2), .SYNC_TIMEOUT(Tmo2), .ENABLE_FWH(1)) dut2 (
    .lpc_clock(lpc_clock), .lpc_reset(lpc_reset), .lpc_ad(lpc_ad), .lpc_frame(lpc_frame),
    .out_cyctype_dir(ct[1]), .out_addr(ad[1]), .out_data(dt[1]), .out_data_size(sz[1]),
    .out_clock_enable(ce[1]), .out_abort(ab[1]), .out_sync_err(se[1])
  );

  always #5 lpc_clock = ~lpc_clock;

  always @(negedge lpc_clock) begin
    for (int d = 0; d < 2; d++) begin
      if (ce[d] === 1'b1) n_ce[d]++;
      if (se[d] === 1'b1) n_se[d]++;
      if (ab[d] === 1'b1) n_ab[d]++;
    end
  end

  task automatic drive(input logic f, input logic [3:0] n);
    lpc_frame = f;
    lpc_ad = n;
    @(posedge lpc_clock);
    #1;
  endtask

  // Expected outcome of one bus cycle, from the protocol rules alone.
  function automatic exp_t model(input txn_t t, input int maxb, input int tmo);
    exp_t e;
    e = '{rec: 1'b0, serr: 1'b0, ct: 4'h0, addr: 32'h0, data: 32'h0, size: 3'd0};
    if (t.kind == KFwh && (t.msize > 4'd2 || t.nbytes > maxb)) return e;
    if (t.nwait >= tmo) begin
      e.serr = 1'b1;
      return e;
    end
    if (t.sync_final != 4'b0000 && t.sync_final != 4'b1010) begin
      e.serr = 1'b1;
      return e;
    end
    e.rec  = 1'b1;
    e.serr = (t.sync_final == 4'b1010);
    e.ct   = {(t.kind == KIo) ? 2'b00 : (t.kind == KMem) ? 2'b01 : 2'b11, t.write, 1'b0};
    e.addr = (t.kind == KIo) ? (t.addr & 32'h0000ffff) :
             (t.kind == KMem) ? t.addr : (t.addr & 32'h0fffffff);
    e.data = (t.nbytes == 1) ? (t.data & 32'hff) :
             (t.nbytes == 2) ? (t.data & 32'hffff) : t.data;
    e.size = 3'(t.nbytes);
    return e;
  endfunction

  function automatic txn_t base(input int kind, input bit write);
    txn_t t;
    t.kind = kind;
    t.write = write;
    t.addr = 32'h0;
    t.data = 32'h0;
    t.msize = 4'b0000;
    t.nbytes = 1;
    t.pre = 0;
    t.pre_nib = 4'h0;
    t.nwait = 0;
    t.wait_code = 4'b0101;
    t.sync_final = 4'b0000;
    return t;
  endfunction

  // Drives one full bus cycle plus one idle clock; latches strobes right after the
  // nibble that should complete the record.
  task automatic send(input txn_t t);
    logic [4:0] q[$];
    logic [4:0] e;
    int mark;
    int naddr;
    for (int i = 0; i < t.pre; i++) q.push_back({1'b0, t.pre_nib});
    if (t.kind == KFwh) q.push_back({1'b0, t.write ? 4'b1110 : 4'b1101});
    else q.push_back(5'b00000);
    if (t.kind == KFwh) q.push_back({1'b1, 4'($urandom_range(0, 15))});
    else q.push_back({2'b10, t.kind == KMem, t.write, 1'b0});
    naddr = (t.kind == KIo) ? 4 : (t.kind == KMem) ? 8 : 7;
    for (int i = naddr - 1; i >= 0; i--) q.push_back({1'b1, t.addr[4*i +: 4]});
    if (t.kind == KFwh) q.push_back({1'b1, t.msize});
    if (t.write) for (int i = 0; i < 2 * t.nbytes; i++) q.push_back({1'b1, t.data[4*i +: 4]});
    q.push_back(5'h1f);
    q.push_back(5'h1f);
    for (int i = 0; i < t.nwait; i++) q.push_back({1'b1, t.wait_code});
    q.push_back({1'b1, t.sync_final});
    if (!t.write) for (int i = 0; i < 2 * t.nbytes; i++) q.push_back({1'b1, t.data[4*i +: 4]});
    mark = q.size() - 1;
    if (t.write) mark = mark - 2 * 0;
    if (t.write) mark = q.size() - 1;
    q.push_back(5'h1f);
    q.push_back(5'h1f);
    q.push_back(5'h1f);
    for (int i = 0; i < q.size(); i++) begin
      e = q[i];
      drive(e[4], e[3:0]);
      if (i == mark) begin
        for (int d = 0; d < 2; d++) begin
          mark_ce[d] = ce[d];
          mark_se[d] = se[d];
        end
      end
    end
  endtask

  task automatic test_reset();
    lpc_reset = 1'b1;
    repeat (3) drive(1'b1, 4'hf);
    n_checks++;
    if ({ct[0], ad[0], dt[0], sz[0], ce[0], ab[0], se[0]} !== 78'h0)
      $display("FAIL reset outputs: got %h want 0", {ct[0], ad[0], dt[0], sz[0], ce[0], ab[0], se[0]});
    else n_pass++;
    lpc_reset = 1'b0;
    drive(1'b1, 4'hf);
    n_checks++;
    if (ce[0] !== 1'b0) $display("FAIL reset no strobe: got %b want 0", ce[0]);
    else n_pass++;
  endtask

  task automatic test_io_read();
    txn_t t;
    int c0;
    t = base(KIo, 1'b0);
    t.pre = 2;
    t.pre_nib = 4'h4;
    t.addr = 32'h00007fe5;
    t.data = 32'h6c;
    c0 = n_ce[0];
    send(t);
    n_checks++;
    if (mark_ce[0] !== 1'b1) $display("FAIL io_rd strobe: got %b want 1", mark_ce[0]);
    else n_pass++;
    n_checks++;
    if (ct[0] !== 4'b0000) $display("FAIL io_rd ctdir: got %b want 0000", ct[0]);
    else n_pass++;
    n_checks++;
    if (ad[0] !== 32'h00007fe5) $display("FAIL io_rd addr: got %h want 00007fe5", ad[0]);
    else n_pass++;
    n_checks++;
    if (dt[0] !== 32'h6c || sz[0] !== 3'd1)
      $display("FAIL io_rd data/size: got %h/%0d want 6c/1", dt[0], sz[0]);
    else n_pass++;
    n_checks++;
    if (n_ce[0] - c0 !== 1) $display("FAIL io_rd strobe count: got %0d want 1", n_ce[0] - c0);
    else n_pass++;
  endtask

  task automatic test_mem_write();
    txn_t t;
    t = base(KMem, 1'b1);
    t.addr = 32'hffff0010;
    t.data = 32'ha5;
    t.nwait = 2;
    t.wait_code = 4'b0101;
    send(t);
    n_checks++;
    if (mark_ce[0] !== 1'b1 || mark_se[0] !== 1'b0)
      $display("FAIL mem_wr strobe/err: got %b/%b want 1/0", mark_ce[0], mark_se[0]);
    else n_pass++;
    n_checks++;
    if (ct[0] !== 4'b0110) $display("FAIL mem_wr ctdir: got %b want 0110", ct[0]);
    else n_pass++;
    n_checks++;
    if (ad[0] !== 32'hffff0010 || dt[0] !== 32'ha5)
      $display("FAIL mem_wr addr/data: got %h/%h want ffff0010/a5", ad[0], dt[0]);
    else n_pass++;
  endtask

  task automatic test_fwh_read();
    txn_t t;
    int c1;
    t = base(KFwh, 1'b0);
    t.addr = 32'h0fffffc0;
    t.msize = 4'b0010;
    t.nbytes = 4;
    t.data = 32'h44332211;
    c1 = n_ce[1];
    send(t);
    n_checks++;
    if (mark_ce[0] !== 1'b1 || ct[0] !== 4'b1100)
      $display("FAIL fwh_rd strobe/ctdir: got %b/%b want 1/1100", mark_ce[0], ct[0]);
    else n_pass++;
    n_checks++;
    if (ad[0] !== 32'h0fffffc0) $display("FAIL fwh_rd addr: got %h want 0fffffc0", ad[0]);
    else n_pass++;
    n_checks++;
    if (dt[0] !== 32'h44332211 || sz[0] !== 3'd4)
      $display("FAIL fwh_rd data/size: got %h/%0d want 44332211/4", dt[0], sz[0]);
    else n_pass++;
    n_checks++;
    if (n_ce[1] - c1 !== 0) $display("FAIL fwh_rd max2 drop: got %0d strobes want 0", n_ce[1] - c1);
    else n_pass++;
  endtask

  task automatic test_abort();
    txn_t t;
    int c0;
    int a0;
    c0 = n_ce[0];
    a0 = n_ab[0];
    drive(1'b0, 4'b0000);
    drive(1'b1, 4'b0010);
    drive(1'b1, 4'h1);
    drive(1'b1, 4'h2);
    drive(1'b0, 4'hf);
    n_checks++;
    if (ab[0] !== 1'b1) $display("FAIL abort pulse: got %b want 1", ab[0]);
    else n_pass++;
    repeat (3) drive(1'b0, 4'hf);
    drive(1'b1, 4'hf);
    n_checks++;
    if (n_ab[0] - a0 !== 1 || n_ce[0] - c0 !== 0)
      $display("FAIL abort counts: got %0d aborts %0d strobes want 1 0", n_ab[0] - a0, n_ce[0] - c0);
    else n_pass++;
    t = base(KIo, 1'b0);
    t.pre = 1;
    t.addr = 32'h000003f8;
    t.data = 32'h5a;
    send(t);
    n_checks++;
    if (mark_ce[0] !== 1'b1 || ad[0] !== 32'h3f8 || dt[0] !== 32'h5a)
      $display("FAIL abort recover: got %b %h %h want 1 3f8 5a", mark_ce[0], ad[0], dt[0]);
    else n_pass++;
  endtask

  task automatic test_sync();
    txn_t t;
    int c0;
    int s0;
    t = base(KMem, 1'b0);
    t.addr = 32'h12345678;
    t.data = 32'h9e;
    t.nwait = 255;
    t.wait_code = 4'b0110;
    c0 = n_ce[0];
    s0 = n_se[0];
    send(t);
    n_checks++;
    if (n_se[0] - s0 !== 1 || n_ce[0] - c0 !== 0)
      $display("FAIL sync timeout: got %0d err %0d strobes want 1 0", n_se[0] - s0, n_ce[0] - c0);
    else n_pass++;
    t.nwait = 254;
    send(t);
    n_checks++;
    if (mark_ce[0] !== 1'b1 || dt[0] !== 32'h9e)
      $display("FAIL sync 254 waits: got %b/%h want 1/9e", mark_ce[0], dt[0]);
    else n_pass++;
    t.nwait = 0;
    t.sync_final = 4'b1010;
    t.data = 32'h3c;
    send(t);
    n_checks++;
    if (mark_ce[0] !== 1'b1 || mark_se[0] !== 1'b1 || dt[0] !== 32'h3c)
      $display("FAIL sync 1010: got %b/%b/%h want 1/1/3c", mark_ce[0], mark_se[0], dt[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    txn_t t;
    drive(1'b0, 4'b0000);
    drive(1'b1, 4'b0000);
    drive(1'b1, 4'h1);
    drive(1'b1, 4'h2);
    drive(1'b1, 4'h3);
    drive(1'b1, 4'h4);
    drive(1'b1, 4'hf);
    drive(1'b1, 4'hf);
    drive(1'b1, 4'b0000);
    drive(1'b1, 4'h5);
    lpc_reset = 1'b1;
    drive(1'b1, 4'h6);
    n_checks++;
    if ({ct[0], ad[0], dt[0], sz[0], ce[0], ab[0], se[0]} !== 78'h0)
      $display("FAIL reset mid-cycle: got %h want 0", {ct[0], ad[0], dt[0], sz[0]});
    else n_pass++;
    lpc_reset = 1'b0;
    drive(1'b1, 4'hf);
    t = base(KIo, 1'b0);
    t.addr = 32'h00000080;
    t.data = 32'he7;
    send(t);
    n_checks++;
    if (mark_ce[0] !== 1'b1 || ad[0] !== 32'h80 || dt[0] !== 32'he7)
      $display("FAIL reset recover: got %b %h %h want 1 80 e7", mark_ce[0], ad[0], dt[0]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    txn_t t;
    exp_t e;
    int c[2];
    int s[2];
    int a[2];
    int r;
    for (int n = 0; n < 40; n++) begin
      t = base($urandom_range(0, 2), 1'($urandom_range(0, 1)));
      t.addr = $urandom;
      t.data = $urandom;
      if (t.kind == KFwh) begin
        t.msize = 4'($urandom_range(0, 3));
        t.nbytes = (t.msize == 4'd0) ? 1 : (t.msize == 4'd1) ? 2 : (t.msize == 4'd2) ? 4 : 1;
      end
      t.pre = $urandom_range(0, 2);
      t.pre_nib = 4'($urandom_range(0, 14));
      t.nwait = $urandom_range(0, 5);
      t.wait_code = ($urandom_range(0, 1) == 0) ? 4'b0101 : 4'b0110;
      r = $urandom_range(0, 9);
      t.sync_final = (r < 7) ? 4'b0000 : (r < 9) ? 4'b1010 : 4'b0011;
      for (int d = 0; d < 2; d++) begin
        c[d] = n_ce[d];
        s[d] = n_se[d];
        a[d] = n_ab[d];
      end
      send(t);
      for (int d = 0; d < 2; d++) begin
        e = (d == 0) ? model(t, 4, 255) : model(t, Max2, Tmo2);
        n_checks++;
        if (mark_ce[d] !== e.rec || n_ce[d] - c[d] !== int'(e.rec))
          $display("FAIL rnd%0d dut%0d strobe: got %b (%0d) want %b", n, d, mark_ce[d],
                   n_ce[d] - c[d], e.rec);
        else n_pass++;
        n_checks++;
        if (n_se[d] - s[d] !== int'(e.serr) || n_ab[d] - a[d] !== 0)
          $display("FAIL rnd%0d dut%0d err/abort: got %0d/%0d want %0d/0", n, d,
                   n_se[d] - s[d], n_ab[d] - a[d], e.serr);
        else n_pass++;
        if (e.rec) begin
          n_checks++;
          if (ct[d] !== e.ct || ad[d] !== e.addr || dt[d] !== e.data || sz[d] !== e.size ||
              mark_se[d] !== e.serr)
            $display("FAIL rnd%0d dut%0d record: got %b %h %h %0d %b want %b %h %h %0d %b", n, d,
                     ct[d], ad[d], dt[d], sz[d], mark_se[d], e.ct, e.addr, e.data, e.size, e.serr);
          else n_pass++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_io_read();
    test_mem_write();
    test_fwh_read();
    test_abort();
    test_sync();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
